// File: rtl/wb_pkg.sv
// Shared writeback types and constants for the MEM/WB stage buffer.
package wb_pkg;

  localparam int unsigned WB_XLEN = 32;
  localparam int unsigned RD_W    = 5;
  localparam int unsigned MAX_CH  = 4;

  typedef struct packed {
    logic [RD_W-1:0]    rd;
    logic               en;
    logic [WB_XLEN-1:0] value;
  } wb_ch_t;

  typedef wb_ch_t [MAX_CH-1:0] wb_pkt_t;

  localparam logic            DISABLE = 1'b0;
  localparam logic [RD_W-1:0] ZERO    = '0;

endpackage

// File: rtl/wb_stage_buffer_if.sv
// Elastic writeback bus: ingress packet, egress head packet, forwarding lookups.
interface wb_stage_buffer_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NUM_CH = 1,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned NUM_RS = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                     flush;
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [NUM_CH*5-1:0]      in_rd_i;
  logic [NUM_CH-1:0]        in_wb_en_i;
  logic [NUM_CH*XLEN-1:0]   in_value_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [NUM_CH*5-1:0]      wb_rd_o;
  logic [NUM_CH-1:0]        wb_en_o;
  logic [NUM_CH*XLEN-1:0]   wb_value_o;
  logic [CNT_W-1:0]         count_o;
  logic [NUM_RS*5-1:0]      rs_addr_i;
  logic [NUM_RS-1:0]        fwd_hit_o;
  logic [NUM_RS*XLEN-1:0]   fwd_value_o;

  modport master (
    output flush, in_valid_i, in_rd_i, in_wb_en_i, in_value_i, out_ready_i, rs_addr_i,
    input  in_ready_o, out_valid_o, wb_rd_o, wb_en_o, wb_value_o, count_o,
           fwd_hit_o, fwd_value_o
  );

  modport slave (
    input  flush, in_valid_i, in_rd_i, in_wb_en_i, in_value_i, out_ready_i, rs_addr_i,
    output in_ready_o, out_valid_o, wb_rd_o, wb_en_o, wb_value_o, count_o,
           fwd_hit_o, fwd_value_o
  );
endinterface

// File: rtl/wb_fifo_core.sv
// Circular packet store with wrapping pointers, occupancy count and synchronous flush.
module wb_fifo_core #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             n_rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & (count_q != '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Flush wins over push and pop; stored data is left stale but unreachable.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk_i or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wb_stage_buffer.sv
// Multi-entry MEM/WB buffer: sanitises x0 writes, gates the head packet and
// forwards operands from the head entry.
module wb_stage_buffer
  import wb_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NUM_CH = 1,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned NUM_RS = 2
) (
  input logic               clk_i,
  input logic               n_rst,
  wb_stage_buffer_if.slave  bus
);

  localparam int unsigned CH_W  = RD_W + 1 + XLEN;
  localparam int unsigned PKT_W = NUM_CH * CH_W;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            en;
    logic [XLEN-1:0] value;
  } ch_t;

  ch_t [NUM_CH-1:0] in_pkt, head_raw, head;
  logic [CNT_W-1:0] count;
  logic             full, out_valid, push, pop;

  assign out_valid       = (count != '0);
  assign push            = bus.in_valid_i & ~full;
  assign pop             = out_valid & bus.out_ready_i;
  assign bus.in_ready_o  = ~full;
  assign bus.out_valid_o = out_valid;
  assign bus.count_o     = count;

  // A write to x0 is stored disabled so it can never reach the register file.
  always_comb begin
    in_pkt = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      in_pkt[c].rd    = bus.in_rd_i[c*RD_W +: RD_W];
      in_pkt[c].en    = (bus.in_rd_i[c*RD_W +: RD_W] == ZERO) ? DISABLE : bus.in_wb_en_i[c];
      in_pkt[c].value = bus.in_value_i[c*XLEN +: XLEN];
    end
  end

  wb_fifo_core #(
    .DEPTH (DEPTH),
    .W     (PKT_W)
  ) u_fifo (
    .clk_i (clk_i),
    .n_rst (n_rst),
    .flush (bus.flush),
    .push  (push),
    .pop   (pop),
    .wdata (in_pkt),
    .rdata (head_raw),
    .count (count),
    .full  (full)
  );

  assign head = out_valid ? head_raw : '0;

  always_comb begin
    bus.wb_rd_o    = '0;
    bus.wb_en_o    = '0;
    bus.wb_value_o = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      bus.wb_rd_o[c*RD_W +: RD_W]    = head[c].rd;
      bus.wb_en_o[c]                 = head[c].en;
      bus.wb_value_o[c*XLEN +: XLEN] = head[c].value;
    end
  end

  // Ascending scan so the highest matching channel overrides lower ones.
  always_comb begin
    bus.fwd_hit_o   = '0;
    bus.fwd_value_o = '0;
    for (int unsigned r = 0; r < NUM_RS; r++) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (head[c].en && (head[c].rd == bus.rs_addr_i[r*RD_W +: RD_W]) &&
            (bus.rs_addr_i[r*RD_W +: RD_W] != ZERO)) begin
          bus.fwd_hit_o[r]                = 1'b1;
          bus.fwd_value_o[r*XLEN +: XLEN] = head[c].value;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_buffer.sv
// Scoreboard bench for wb_stage_buffer with two channels and two entries.
module tb_wb_stage_buffer;
  import wb_pkg::*;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NUM_CH = 2;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned NUM_RS = 2;

  typedef wb_ch_t [NUM_CH-1:0] pkt_t;

  logic clk_i = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk_i = ~clk_i;

  wb_stage_buffer_if #(.XLEN(XLEN), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .NUM_RS(NUM_RS)) bus ();

  wb_stage_buffer #(.XLEN(XLEN), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .NUM_RS(NUM_RS)) dut (
    .clk_i (clk_i),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  pkt_t sb[$];
  pkt_t got, exp;

  function automatic pkt_t mk(logic [4:0] rd1, logic en1, logic [31:0] v1,
                              logic [4:0] rd0, logic en0, logic [31:0] v0);
    pkt_t p;
    p[1] = '{rd: rd1, en: en1, value: v1};
    p[0] = '{rd: rd0, en: en0, value: v0};
    return p;
  endfunction

  function automatic pkt_t san(pkt_t p);
    pkt_t s = p;
    for (int c = 0; c < NUM_CH; c++) if (s[c].rd == 5'd0) s[c].en = 1'b0;
    return s;
  endfunction

  function automatic pkt_t head_pkt();
    pkt_t h;
    for (int c = 0; c < NUM_CH; c++) begin
      h[c].rd    = bus.wb_rd_o[c*5 +: 5];
      h[c].en    = bus.wb_en_o[c];
      h[c].value = bus.wb_value_o[c*XLEN +: XLEN];
    end
    return h;
  endfunction

  task automatic drive(pkt_t p, logic v);
    bus.in_valid_i = v;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.in_rd_i[c*5 +: 5]          = p[c].rd;
      bus.in_wb_en_i[c]              = p[c].en;
      bus.in_value_i[c*XLEN +: XLEN] = p[c].value;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    bus.flush = 1'b0; bus.out_ready_i = 1'b0; bus.rs_addr_i = {5'd3, 5'd5};
    drive(mk(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0), 1'b0);
    #2 n_rst = 1'b0;
    repeat (2) tick();
    n_rst = 1'b1;
    tick();
    n_checks++; if (bus.in_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready_o); end
    n_checks++; if (bus.out_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid_o); end
    n_checks++; if (bus.count_o !== 2'd0) begin n_errors++; $display("FAIL reset_count got=%0d exp=0", bus.count_o); end
    n_checks++; if (bus.wb_en_o !== 2'b00) begin n_errors++; $display("FAIL reset_wb_en got=%b exp=00", bus.wb_en_o); end
    n_checks++; if (bus.wb_rd_o !== 10'd0) begin n_errors++; $display("FAIL reset_wb_rd got=%h exp=0", bus.wb_rd_o); end
    n_checks++; if (bus.wb_value_o !== 64'd0) begin n_errors++; $display("FAIL reset_wb_value got=%h exp=0", bus.wb_value_o); end
    n_checks++; if (bus.fwd_hit_o !== 2'b00) begin n_errors++; $display("FAIL reset_fwd_hit got=%b exp=00", bus.fwd_hit_o); end
    n_checks++; if (bus.fwd_value_o !== 64'd0) begin n_errors++; $display("FAIL reset_fwd_value got=%h exp=0", bus.fwd_value_o); end
  endtask

  task automatic test_single();
    pkt_t p = mk(5'd0, 1'b1, 32'h0000_1234, 5'd5, 1'b1, 32'hDEAD_BEEF);
    drive(p, 1'b1); sb.push_back(san(p));
    tick();
    drive(p, 1'b0);
    n_checks++; if (bus.wb_en_o !== 2'b01) begin n_errors++; $display("FAIL single_wb_en got=%b exp=01", bus.wb_en_o); end
    n_checks++; if (bus.wb_rd_o[4:0] !== 5'd5) begin n_errors++; $display("FAIL single_wb_rd got=%0d exp=5", bus.wb_rd_o[4:0]); end
    n_checks++; if (bus.wb_value_o[31:0] !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL single_wb_value got=%h exp=deadbeef", bus.wb_value_o[31:0]); end
    n_checks++; if (bus.count_o !== 2'd1) begin n_errors++; $display("FAIL single_count got=%0d exp=1", bus.count_o); end
    bus.rs_addr_i = {5'd0, 5'd5}; #1;
    n_checks++; if (bus.fwd_hit_o !== 2'b01) begin n_errors++; $display("FAIL single_fwd_hit got=%b exp=01", bus.fwd_hit_o); end
    n_checks++; if (bus.fwd_value_o !== {32'd0, 32'hDEAD_BEEF}) begin n_errors++; $display("FAIL single_fwd_value got=%h exp=00000000deadbeef", bus.fwd_value_o); end
    bus.rs_addr_i = {5'd0, 5'd0}; #1;
    n_checks++; if (bus.fwd_hit_o !== 2'b00) begin n_errors++; $display("FAIL single_fwd_x0 got=%b exp=00", bus.fwd_hit_o); end
    bus.out_ready_i = 1'b1;
    got = head_pkt(); exp = sb.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL single_pop got=%h exp=%h", got, exp); end
    tick();
    bus.out_ready_i = 1'b0;
    n_checks++; if (bus.out_valid_o !== 1'b0 || bus.wb_en_o !== 2'b00) begin n_errors++; $display("FAIL single_drain got=%b/%b exp=0/00", bus.out_valid_o, bus.wb_en_o); end
  endtask

  task automatic test_backpressure();
    pkt_t a = mk(5'd0, 1'b0, 32'd0, 5'd1, 1'b1, 32'h0000_000A);
    pkt_t b = mk(5'd2, 1'b1, 32'h0000_00B1, 5'd3, 1'b1, 32'h0000_00B0);
    pkt_t c = mk(5'd4, 1'b1, 32'h0000_00C1, 5'd4, 1'b1, 32'h0000_00C0);
    bus.out_ready_i = 1'b0;
    drive(a, 1'b1); sb.push_back(san(a)); tick();
    drive(b, 1'b1); sb.push_back(san(b)); tick();
    n_checks++; if (bus.count_o !== 2'd2 || bus.in_ready_o !== 1'b0) begin n_errors++; $display("FAIL bp_full got=%0d/%b exp=2/0", bus.count_o, bus.in_ready_o); end
    drive(c, 1'b1); tick();
    drive(c, 1'b0);
    n_checks++; if (bus.count_o !== 2'd2) begin n_errors++; $display("FAIL bp_reject got=%0d exp=2", bus.count_o); end
    bus.out_ready_i = 1'b1;
    got = head_pkt(); exp = sb.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL bp_pop_a got=%h exp=%h", got, exp); end
    tick();
    n_checks++; if (bus.in_ready_o !== 1'b1 || bus.count_o !== 2'd1) begin n_errors++; $display("FAIL bp_ready_back got=%b/%0d exp=1/1", bus.in_ready_o, bus.count_o); end
    got = head_pkt(); exp = sb.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL bp_pop_b got=%h exp=%h", got, exp); end
    tick();
    bus.out_ready_i = 1'b0;
    n_checks++; if (bus.out_valid_o !== 1'b0 || bus.count_o !== 2'd0) begin n_errors++; $display("FAIL bp_empty got=%b/%0d exp=0/0", bus.out_valid_o, bus.count_o); end
  endtask

  task automatic test_back_to_back();
    pkt_t p = mk(5'd0, 1'b0, 32'd0, 5'd1, 1'b1, 32'd100);
    bus.out_ready_i = 1'b0;
    drive(p, 1'b1); sb.push_back(san(p)); tick();
    for (int i = 1; i <= 10; i++) begin
      p = mk(5'd0, 1'b0, 32'd0, 5'(i), 1'b1, 32'(i));
      drive(p, 1'b1); sb.push_back(san(p));
      bus.out_ready_i = 1'b1;
      got = head_pkt(); exp = sb.pop_front();
      n_checks++; if (got !== exp) begin n_errors++; $display("FAIL b2b_lag_%0d got=%h exp=%h", i, got, exp); end
      tick();
      n_checks++; if (bus.count_o !== 2'd1) begin n_errors++; $display("FAIL b2b_count_%0d got=%0d exp=1", i, bus.count_o); end
    end
    drive(p, 1'b0);
    got = head_pkt(); exp = sb.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL b2b_last got=%h exp=%h", got, exp); end
    tick();
    bus.out_ready_i = 1'b0;
    n_checks++; if (bus.count_o !== 2'd0) begin n_errors++; $display("FAIL b2b_drain got=%0d exp=0", bus.count_o); end
  endtask

  task automatic test_flush();
    pkt_t p = mk(5'd0, 1'b0, 32'd0, 5'd3, 1'b1, 32'h30);
    pkt_t q = mk(5'd0, 1'b0, 32'd0, 5'd4, 1'b1, 32'h40);
    pkt_t r = mk(5'd9, 1'b1, 32'h99, 5'd9, 1'b1, 32'h98);
    bus.out_ready_i = 1'b0;
    drive(p, 1'b1); tick();
    drive(q, 1'b1); tick();
    drive(r, 1'b1); bus.flush = 1'b1; tick();
    bus.flush = 1'b0; drive(r, 1'b0);
    n_checks++; if (bus.count_o !== 2'd0 || bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin n_errors++; $display("FAIL flush_full got=%0d/%b/%b exp=0/0/1", bus.count_o, bus.out_valid_o, bus.in_ready_o); end
    drive(p, 1'b1); tick();
    drive(r, 1'b1); bus.flush = 1'b1; tick();
    bus.flush = 1'b0; drive(r, 1'b0);
    n_checks++; if (bus.count_o !== 2'd0 || bus.out_valid_o !== 1'b0) begin n_errors++; $display("FAIL flush_push got=%0d/%b exp=0/0", bus.count_o, bus.out_valid_o); end
    repeat (2) tick();
    n_checks++; if (bus.out_valid_o !== 1'b0 || bus.wb_en_o !== 2'b00) begin n_errors++; $display("FAIL flush_dropped got=%b/%b exp=0/00", bus.out_valid_o, bus.wb_en_o); end
  endtask

  task automatic test_fwd_priority();
    pkt_t f1 = mk(5'd7, 1'b1, 32'h22, 5'd7, 1'b1, 32'h11);
    pkt_t f2 = mk(5'd7, 1'b0, 32'h22, 5'd7, 1'b1, 32'h11);
    bus.out_ready_i = 1'b0;
    drive(f1, 1'b1); sb.push_back(san(f1)); tick();
    drive(f1, 1'b0);
    bus.rs_addr_i = {5'd7, 5'd7}; #1;
    n_checks++; if (bus.fwd_hit_o !== 2'b11 || bus.fwd_value_o !== {32'h22, 32'h22}) begin n_errors++; $display("FAIL fwd_high_wins got=%b/%h exp=11/0000002200000022", bus.fwd_hit_o, bus.fwd_value_o); end
    bus.out_ready_i = 1'b1;
    got = head_pkt(); exp = sb.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL fwd_pop1 got=%h exp=%h", got, exp); end
    tick();
    bus.out_ready_i = 1'b0;
    n_checks++; if (bus.fwd_hit_o !== 2'b00 || bus.fwd_value_o !== 64'd0) begin n_errors++; $display("FAIL fwd_empty got=%b/%h exp=00/0", bus.fwd_hit_o, bus.fwd_value_o); end
    drive(f2, 1'b1); sb.push_back(san(f2)); tick();
    drive(f2, 1'b0);
    bus.rs_addr_i = {5'd8, 5'd7}; #1;
    n_checks++; if (bus.fwd_hit_o !== 2'b01 || bus.fwd_value_o !== {32'h0, 32'h11}) begin n_errors++; $display("FAIL fwd_en_off got=%b/%h exp=01/0000000000000011", bus.fwd_hit_o, bus.fwd_value_o); end
    bus.out_ready_i = 1'b1;
    got = head_pkt(); exp = sb.pop_front();
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL fwd_pop2 got=%h exp=%h", got, exp); end
    tick();
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_async_reset();
    pkt_t p = mk(5'd6, 1'b1, 32'h66, 5'd5, 1'b1, 32'h55);
    bus.out_ready_i = 1'b0;
    drive(p, 1'b1); tick();
    drive(p, 1'b0);
    #2 n_rst = 1'b0;
    #1;
    n_checks++; if (bus.count_o !== 2'd0 || bus.out_valid_o !== 1'b0 || bus.wb_en_o !== 2'b00) begin n_errors++; $display("FAIL async_reset got=%0d/%b/%b exp=0/0/00", bus.count_o, bus.out_valid_o, bus.wb_en_o); end
    tick();
    n_rst = 1'b1;
    tick();
    n_checks++; if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin n_errors++; $display("FAIL async_release got=%b/%b exp=1/0", bus.in_ready_o, bus.out_valid_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_fwd_priority();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
